// File: rtl/lc3_data_mem_responder.sv
// LC3 data-memory responder: word-addressed 16-bit RAM that answers
// read/write requests after a fixed number of wait states.
module lc3_data_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Data_en,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  output logic        busy
);

  if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_rl
    $error("READ_LATENCY must be in 1..7");
  end
  if (WRITE_LATENCY < 1 || WRITE_LATENCY > 7) begin : g_bad_wl
    $error("WRITE_LATENCY must be in 1..7");
  end

  localparam logic [2:0] RL = 3'(READ_LATENCY);
  localparam logic [2:0] WL = 3'(WRITE_LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q;
  logic [2:0]             cnt_q;
  logic                   rd_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [15:0]            din_q;
  logic [15:0]            mem_q [2**ADDR_BITS];

  logic                   accept;
  logic [2:0]             lat;
  logic                   fire;
  logic                   f_rd;
  logic [ADDR_BITS-1:0]   f_addr;
  logic [15:0]            f_din;
  logic                   unused_addr;

  assign unused_addr = ^Data_addr[15:ADDR_BITS];
  assign accept      = Data_en && (state_q != BUSY);
  assign lat         = Data_rd ? RL : WL;

  // fire marks the edge that enters DONE; the memory action happens there
  // so Data_dout is already valid while complete_data is high.
  always_comb begin
    fire   = 1'b0;
    f_rd   = rd_q;
    f_addr = addr_q;
    f_din  = din_q;
    if (state_q == BUSY) begin
      fire = (cnt_q == 3'd1);
    end else if (accept && lat == 3'd1) begin
      fire   = 1'b1;
      f_rd   = Data_rd;
      f_addr = Data_addr[ADDR_BITS-1:0];
      f_din  = Data_din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      Data_dout     <= 16'h0000;
      complete_data <= 1'b0;
      busy          <= 1'b0;
    end else begin
      complete_data <= fire;
      if (fire && f_rd) begin
        Data_dout <= mem_q[f_addr];
      end
      case (state_q)
        BUSY: begin
          cnt_q <= cnt_q - 3'd1;
          busy  <= !fire;
          if (fire) state_q <= DONE;
        end
        default: begin
          if (accept) begin
            rd_q   <= Data_rd;
            addr_q <= Data_addr[ADDR_BITS-1:0];
            din_q  <= Data_din;
            if (lat == 3'd1) begin
              state_q <= DONE;
              cnt_q   <= 3'd0;
              busy    <= 1'b0;
            end else begin
              state_q <= BUSY;
              cnt_q   <= lat - 3'd1;
              busy    <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

  // A reset on the commit edge suppresses the write (abort).
  always_ff @(posedge clock) begin
    if (reset && fire && !f_rd) begin
      mem_q[f_addr] <= f_din;
    end
  end

endmodule

// File: tb/tb_lc3_data_mem_responder.sv
// Self-checking bench: transaction-level reference model, directed cases
// and randomized traffic; a slow-latency instance exercises abort.
module tb_lc3_data_mem_responder;

  localparam int RL = 2;
  localparam int WL = 1;

  logic        clock;
  logic        reset;
  logic        Data_en;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        busy;

  logic        s_reset;
  logic        s_en;
  logic        s_rd;
  logic [15:0] s_addr;
  logic [15:0] s_din;
  logic [15:0] s_dout;
  logic        s_cd;
  logic        s_busy;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  lc3_data_mem_responder #(
    .ADDR_BITS(8), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clock(clock), .reset(reset), .Data_en(Data_en),
    .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(Data_dout), .complete_data(complete_data), .busy(busy)
  );

  lc3_data_mem_responder #(
    .ADDR_BITS(8), .READ_LATENCY(3), .WRITE_LATENCY(3)
  ) u_slow (
    .clock(clock), .reset(s_reset), .Data_en(s_en),
    .Data_rd(s_rd), .Data_addr(s_addr), .Data_din(s_din),
    .Data_dout(s_dout), .complete_data(s_cd), .busy(s_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a request accepted at edge k completes at edge
  // k+L-1; memory/dout change on that edge, complete pulses after it.
  int          cyc = 0;
  bit          pend = 0;
  bit          prd;
  logic [7:0]  paddr;
  logic [15:0] pdin;
  int          done_at;
  logic [15:0] mmem [256];
  bit          mknown [256];
  bit          dknown = 1;
  logic        m_cd = 0;
  logic        m_busy = 0;
  logic [15:0] m_dout = 16'h0;

  always @(posedge clock) begin
    cyc++;
    m_cd = 1'b0;
    if (!reset) begin
      pend   = 0;
      m_busy = 1'b0;
      m_dout = 16'h0;
      dknown = 1;
    end else begin
      if (!pend && Data_en) begin
        pend    = 1;
        prd     = Data_rd;
        paddr   = Data_addr[7:0];
        pdin    = Data_din;
        done_at = cyc + (Data_rd ? RL : WL) - 1;
      end
      if (pend && cyc == done_at) begin
        if (prd) begin
          m_dout = mmem[paddr];
          dknown = mknown[paddr];
        end else begin
          mmem[paddr]   = pdin;
          mknown[paddr] = 1;
        end
        m_cd = 1'b1;
        pend = 0;
      end
      m_busy = pend;
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("model complete_data", 16'(complete_data), 16'(m_cd));
      chk("model busy", 16'(busy), 16'(m_busy));
      if (dknown) chk("model Data_dout", Data_dout, m_dout);
    end
  end

  task automatic drive(bit en, bit rd, logic [15:0] a, logic [15:0] d);
    Data_en   = en;
    Data_rd   = rd;
    Data_addr = a;
    Data_din  = d;
  endtask

  task automatic sdrive(bit en, bit rd, logic [15:0] a, logic [15:0] d);
    s_en   = en;
    s_rd   = rd;
    s_addr = a;
    s_din  = d;
  endtask

  int pulses;

  initial begin
    for (int i = 0; i < 256; i++) mknown[i] = 0;
    reset   = 1'b0;
    s_reset = 1'b0;
    drive(1, 1, 16'h0, 16'h0);
    sdrive(1, 1, 16'h0, 16'h0);
    chk_on = 1;

    // reset held with Data_en active
    repeat (3) begin
      @(negedge clock);
      chk("reset dout", Data_dout, 16'h0000);
      chk("reset complete", 16'(complete_data), 16'h0);
      chk("reset busy", 16'(busy), 16'h0);
    end
    reset   = 1'b1;
    s_reset = 1'b1;
    drive(0, 0, 16'h0, 16'h0);
    sdrive(0, 0, 16'h0, 16'h0);
    @(negedge clock);

    // preload every word, back-to-back writes
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 16'(i), 16'($urandom));
      @(negedge clock);
    end
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clock);

    // write then read
    drive(1, 0, 16'h0010, 16'hBEEF);
    @(negedge clock);
    drive(0, 0, 16'h0, 16'h0);
    chk("wr lat1 complete", 16'(complete_data), 16'h1);
    @(negedge clock);
    drive(1, 1, 16'h0010, 16'h0);
    @(negedge clock);
    drive(0, 0, 16'h0, 16'h0);
    chk("rd cycle1 complete", 16'(complete_data), 16'h0);
    chk("rd cycle1 busy", 16'(busy), 16'h1);
    @(negedge clock);
    chk("rd lat2 complete", 16'(complete_data), 16'h1);
    chk("rd BEEF", Data_dout, 16'hBEEF);

    // back-to-back read in the write's DONE cycle
    @(negedge clock);
    drive(1, 0, 16'h0020, 16'h1234);
    @(negedge clock);
    chk("b2b wr complete", 16'(complete_data), 16'h1);
    drive(1, 1, 16'h0020, 16'h0);
    @(negedge clock);
    drive(0, 0, 16'h0, 16'h0);
    chk("b2b no bubble busy", 16'(busy), 16'h1);
    @(negedge clock);
    chk("b2b rd complete", 16'(complete_data), 16'h1);
    chk("b2b 1234", Data_dout, 16'h1234);

    // address wrap
    @(negedge clock);
    drive(1, 0, 16'hFF03, 16'hA5A5);
    @(negedge clock);
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clock);
    drive(1, 1, 16'h0003, 16'h0);
    @(negedge clock);
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("wrap A5A5", Data_dout, 16'hA5A5);

    // request while busy is dropped
    @(negedge clock);
    pulses = 0;
    drive(1, 1, 16'h0003, 16'h0);
    @(negedge clock);
    pulses += int'(complete_data);
    drive(1, 0, 16'h0003, 16'h0000);
    @(negedge clock);
    drive(0, 0, 16'h0, 16'h0);
    repeat (4) begin
      pulses += int'(complete_data);
      @(negedge clock);
    end
    chk("ignored pulses", 16'(pulses), 16'd1);
    drive(1, 1, 16'h0003, 16'h0);
    @(negedge clock);
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("ignored mem3", Data_dout, 16'hA5A5);

    // abort on the slow instance
    sdrive(1, 0, 16'h0040, 16'h1111);
    @(negedge clock);
    sdrive(0, 0, 16'h0, 16'h0);
    repeat (4) @(negedge clock);
    pulses = 0;
    sdrive(1, 0, 16'h0040, 16'h7777);
    @(negedge clock);
    sdrive(0, 0, 16'h0, 16'h0);
    chk("abort busy before", 16'(s_busy), 16'h1);
    s_reset = 1'b0;
    @(negedge clock);
    s_reset = 1'b1;
    chk("abort busy after", 16'(s_busy), 16'h0);
    repeat (4) begin
      pulses += int'(s_cd);
      @(negedge clock);
    end
    chk("abort pulses", 16'(pulses), 16'd0);
    sdrive(1, 1, 16'h0040, 16'h0);
    @(negedge clock);
    sdrive(0, 0, 16'h0, 16'h0);
    @(negedge clock);
    @(negedge clock);
    chk("abort rd complete", 16'(s_cd), 16'h1);
    chk("abort old data", s_dout, 16'h1111);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom % 150) != 0;
      drive(($urandom % 3) != 0, $urandom % 2,
            16'($urandom), 16'($urandom));
      @(negedge clock);
    end
    drive(0, 0, 16'h0, 16'h0);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
